// File: rtl/hurricane_timer.sv
`default_nettype none
// ============================================================================
//  Module      : hurricane_timer
//  Description : Gear-3 ("hurricane") run-time limiter for an appliance.
//                Gear 3 may be used once per power-on session. A run lasts
//                HURRICANE_SEC seconds; a menu press during the run switches
//                to an EXTEND wind-down of EXTEND_SEC seconds that ends in
//                gear 2 instead of standby.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk                    in   system clock
//    rst                    in   asynchronous active-high reset
//    machine_state          in   1 = appliance powered on
//    mode_state     [2:0]   in   mode code, 3'b011 = gear 3
//    menu_btn               in   single-cycle debounced menu press
//    hurricane_mode_enabled out  1 = gear 3 may be entered / held
//    return_state           out  1 = leave gear 3 to gear 2, 0 = to standby
//    remain_sec     [7:0]   out  seconds left in the active countdown
//    counting               out  1 while RUN or EXTEND is active
// ============================================================================
module hurricane_timer #(
  parameter int CLK_PER_SEC   = 100_000_000,
  parameter int HURRICANE_SEC = 60,
  parameter int EXTEND_SEC    = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       machine_state,
  input  logic [2:0] mode_state,
  input  logic       menu_btn,
  output logic       hurricane_mode_enabled,
  output logic       return_state,
  output logic [7:0] remain_sec,
  output logic       counting
);

  localparam int             c_PRESC_W        = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
  localparam logic [c_PRESC_W-1:0] c_TICK_AT  = c_PRESC_W'(CLK_PER_SEC - 1);
  localparam logic [c_PRESC_W-1:0] c_PRESC_ONE = c_PRESC_W'(1);
  localparam logic [2:0]     c_MODE_HURRICANE = 3'b011;
  localparam logic [7:0]     c_HURR_LOAD      = 8'(HURRICANE_SEC);
  localparam logic [7:0]     c_EXT_LOAD       = 8'(EXTEND_SEC);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RUN    = 3'd1,
    S_EXTEND = 3'd2,
    S_EXIT   = 3'd3,
    S_USED   = 3'd4
  } state_t;

  state_t                 r_state;
  logic [c_PRESC_W-1:0]   r_presc;

  logic w_gear3;
  logic w_tick;

  assign w_gear3 = (mode_state == c_MODE_HURRICANE);
  // The prescaler is held at zero outside RUN/EXTEND, so a tick can only
  // occur while a countdown is active.
  assign w_tick  = (r_presc == c_TICK_AT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state                <= S_IDLE;
      r_presc                <= '0;
      hurricane_mode_enabled <= 1'b1;
      return_state           <= 1'b0;
      remain_sec             <= 8'd0;
      counting               <= 1'b0;
    end else if (!machine_state) begin
      // Power-off overrides everything and re-arms gear 3 for the next session.
      r_state                <= S_IDLE;
      r_presc                <= '0;
      hurricane_mode_enabled <= 1'b1;
      return_state           <= 1'b0;
      remain_sec             <= 8'd0;
      counting               <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_presc <= '0;
          if (w_gear3) begin
            r_state    <= S_RUN;
            remain_sec <= c_HURR_LOAD;
            counting   <= 1'b1;
          end
        end

        S_RUN, S_EXTEND: begin
          if (!w_gear3) begin
            // Gear 3 abandoned early: the session's allowance is spent.
            r_state                <= S_USED;
            r_presc                <= '0;
            hurricane_mode_enabled <= 1'b0;
            return_state           <= 1'b0;
            remain_sec             <= 8'd0;
            counting               <= 1'b0;
          end else if (r_state == S_RUN && menu_btn) begin
            // Checked ahead of the tick so a press on the final tick still
            // reaches the wind-down.
            r_state      <= S_EXTEND;
            r_presc      <= '0;
            return_state <= 1'b1;
            remain_sec   <= c_EXT_LOAD;
          end else begin
            r_presc <= w_tick ? '0 : r_presc + c_PRESC_ONE;
            if (w_tick) begin
              if (remain_sec == 8'd1) begin
                // return_state is left alone: 0 after RUN, 1 after EXTEND.
                r_state                <= S_EXIT;
                hurricane_mode_enabled <= 1'b0;
                remain_sec             <= 8'd0;
                counting               <= 1'b0;
              end else if (remain_sec != 8'd0) begin
                remain_sec <= remain_sec - 8'd1;
              end
            end
          end
        end

        S_EXIT: begin
          r_presc <= '0;
          if (!w_gear3) begin
            r_state      <= S_USED;
            return_state <= 1'b0;
          end
        end

        S_USED: begin
          r_presc <= '0;
        end

        default: begin
          r_state                <= S_IDLE;
          r_presc                <= '0;
          hurricane_mode_enabled <= 1'b1;
          return_state           <= 1'b0;
          remain_sec             <= 8'd0;
          counting               <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/hurricane_timer.md
HURRICANE_TIMER -- requirements
Module: hurricane_timer

Interface
REQ-001 The parameter CLK_PER_SEC SHALL default to 100_000_000 and set the number of clk cycles per second tick.
REQ-002 The parameter HURRICANE_SEC SHALL default to 60 and set the gear-3 run time in seconds (range 1..255).
REQ-003 The parameter EXTEND_SEC SHALL default to 60 and set the wind-down time after a menu press in gear 3, in seconds (range 1..255).
REQ-004 clk  input  1  system clock; the block SHALL use one clock; reset is asynchronous and active-high.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 machine_state  input  1  1 = appliance powered on.
REQ-007 mode_state  input  3  current mode code from the mode FSM (3'b011 = hurricane/gear 3).
REQ-008 menu_btn  input  1  single-cycle debounced menu press pulse.
REQ-009 hurricane_mode_enabled  output  1  1 = gear 3 may be entered or held.
REQ-010 return_state  output  1  1 = on gear-3 exit, go to gear 2; 0 = go to standby.
REQ-011 remain_sec  output  8  seconds remaining in the active countdown, for display.
REQ-012 counting  output  1  1 while a countdown (RUN or EXTEND) is active.

Function
REQ-013 The block SHALL implement the states IDLE, RUN, EXTEND, EXIT and USED.
REQ-014 IDLE: enabled=1, return_state=0, remain_sec=0, counting=0; when mode_state==3'b011, the block SHALL go to RUN on the next edge, load remain_sec=HURRICANE_SEC and clear the prescaler.
REQ-015 Prescaler: the counter SHALL count 0..CLK_PER_SEC-1 and wrap to 0; a tick is the cycle in which the count equals CLK_PER_SEC-1; the counter runs only in RUN and EXTEND.
REQ-016 RUN and EXTEND: each tick SHALL decrement remain_sec by 1, with no underflow.
REQ-017 RUN: a tick while remain_sec==1 SHALL set remain_sec=0, enabled=0 and return_state=0, and move to EXIT.
REQ-018 RUN: a menu_btn pulse SHALL set return_state=1, load remain_sec=EXTEND_SEC, clear the prescaler and move to EXTEND.
REQ-019 RUN: if a menu_btn pulse and the final tick occur in the same cycle, the menu pulse SHALL win (go to EXTEND).
REQ-020 EXTEND: menu_btn SHALL be ignored; a tick while remain_sec==1 SHALL set remain_sec=0 and enabled=0, hold return_state=1, and move to EXIT.
REQ-021 RUN or EXTEND: if mode_state leaves 3'b011 before expiry, the block SHALL go to USED, with enabled=0, return_state=0 and remain_sec=0.
REQ-022 EXIT: enabled=0 and return_state SHALL be held until mode_state!=3'b011, then the block SHALL move to USED on the next edge.
REQ-023 USED: enabled=0, return_state=0, counting=0 until power-off; gear 3 is permitted once per power-on session.
REQ-024 machine_state==0 SHALL have priority over all other events: synchronous return to IDLE, prescaler cleared, outputs at IDLE values, regardless of state.
REQ-025 counting SHALL equal 1 exactly in RUN and EXTEND.
REQ-026 All outputs SHALL be registered, with no combinational path from inputs to outputs.

Reset
REQ-027 rst=1 SHALL asynchronously force IDLE, prescaler=0, hurricane_mode_enabled=1, return_state=0, remain_sec=0 and counting=0.
REQ-028 Assertion of rst mid-countdown SHALL abort the countdown with no residual state; after rst deasserts, gear 3 is permitted again.

Verification (CLK_PER_SEC=10, HURRICANE_SEC=3, EXTEND_SEC=2)
REQ-029 Power on, then mode_state=011 with no menu press -> counting=1 and remain_sec 3,2,1 at 10-cycle spacing; 30 cycles after RUN entry: enabled=0, return_state=0, remain_sec=0; after mode_state=000: USED with enabled=0.
REQ-030 In RUN, menu_btn pulse 15 cycles after entry -> return_state=1, remain_sec=2; 20 cycles later enabled=0 with return_state=1 held; after mode_state=010: return_state=0.
REQ-031 menu_btn pulse in the same cycle as the final RUN tick -> EXTEND, remain_sec=2, enabled stays 1.
REQ-032 machine_state 1->0 during EXTEND -> next edge: IDLE, enabled=1, return_state=0, remain_sec=0; re-entering gear 3 restarts at remain_sec=3.
REQ-033 rst pulse mid-RUN (async, between edges) -> outputs immediately enabled=1, counting=0, remain_sec=0.
REQ-034 USED, then mode_state=011 forced -> enabled stays 0, no countdown starts.
